// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array skew feeder.
// Holds the default array geometry, the feeder state encoding and a helper
// that extracts one lane from a packed lane vector.
package sa_pkg;

  localparam int unsigned ARR_SIZE     = 4;
  localparam int unsigned DATA_BW      = 16;
  localparam int unsigned LEN_W        = 8;
  localparam int unsigned DRAIN_CYCLES = 2 * ARR_SIZE - 1;
  localparam int unsigned VEC_W        = ARR_SIZE * DATA_BW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sa_feed_state_t;

  // Lane idx of a packed vector; lane 0 sits in the least-significant bits.
  function automatic logic [DATA_BW-1:0] lane_slice(input logic [VEC_W-1:0] vec,
                                                    input int unsigned        idx);
    return vec[idx*DATA_BW +: DATA_BW];
  endfunction

endpackage

// File: rtl/sa_skew_lane.sv
// One skew lane: a DEPTH-stage shift register.
// Stage 0 captures i_data when i_load is high and zero otherwise, so every
// non-beat cycle pushes an all-zero bubble down the lane.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   i_load    - load i_data into stage 0 this edge
//   i_data    - element to load
//   o_data    - last stage (element delayed by DEPTH-1 cycles after capture)
module sa_skew_lane #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] sr_q [DEPTH];
  logic [WIDTH-1:0] stage0_d;

  assign stage0_d = i_load ? i_data : '0;

  // Shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        sr_q[k] <= '0;
      end
    end else begin
      sr_q[0] <= stage0_d;
      for (int k = 1; k < int'(DEPTH); k++) begin
        sr_q[k] <= sr_q[k-1];
      end
    end
  end

  assign o_data = sr_q[DEPTH-1];

endmodule

// File: rtl/sa_skew_feeder.sv
// Input staging for the systolic MAC array.
// Takes one unskewed A-column and B-row vector per beat, delays lane i by i
// cycles to form the diagonal wavefront, then flushes zeros until every
// partial product has reached the array's bottom edge and pulses o_done.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   i_start/i_len - start a job of i_len beats (sampled only in IDLE)
//   i_valid       - beat valid; accepted when o_ready is high
//   o_ready       - high while loading beats
//   i_row_vec     - A column, lane i = bits [i*DATA_BW +: DATA_BW]
//   i_col_vec     - B row, same packing
//   o_horizontal  - skewed A lanes
//   o_vertical    - skewed B lanes
//   o_busy        - high in LOAD and DRAIN
//   o_done        - one-cycle completion pulse
module sa_skew_feeder
  import sa_pkg::*;
#(
  parameter int unsigned ARR_SIZE = sa_pkg::ARR_SIZE,
  parameter int unsigned DATA_BW  = sa_pkg::DATA_BW,
  parameter int unsigned LEN_W    = sa_pkg::LEN_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [LEN_W-1:0]            i_len,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [ARR_SIZE*DATA_BW-1:0] i_row_vec,
  input  logic [ARR_SIZE*DATA_BW-1:0] i_col_vec,
  output logic [ARR_SIZE*DATA_BW-1:0] o_horizontal,
  output logic [ARR_SIZE*DATA_BW-1:0] o_vertical,
  output logic                        o_busy,
  output logic                        o_done
);

  // Deepest lane empties in ARR_SIZE-1 cycles, then ARR_SIZE cycles down the array.
  localparam int unsigned DRAIN_LEN = 2 * ARR_SIZE - 1;
  localparam int unsigned DRAIN_W   = $clog2(DRAIN_LEN + 1);

  sa_feed_state_t     state_q, state_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               ready_d, busy_d, done_d;
  logic               accept_c;

  assign accept_c = i_valid && o_ready;

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      drain_q <= drain_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE: begin
        if (i_start && (i_len != '0)) begin
          beat_d  = i_len;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (accept_c) begin
          beat_d = beat_q - LEN_W'(1);
          if (beat_q == LEN_W'(1)) begin
            state_d = DRAIN;
            drain_d = DRAIN_W'(DRAIN_LEN - 1);
          end
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode; ready/busy track the upcoming state, done follows the DONE cycle.
  always_comb begin
    ready_d = (state_d == LOAD);
    busy_d  = (state_d == LOAD) || (state_d == DRAIN);
    done_d  = (state_q == DONE);
  end

  // Registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_ready <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_ready <= ready_d;
      o_busy  <= busy_d;
      o_done  <= done_d;
    end
  end

  // Lane i of each bus is delayed by i cycles (depth i+1).
  for (genvar g = 0; g < int'(ARR_SIZE); g++) begin : g_lane
    sa_skew_lane #(
      .DEPTH (g + 1),
      .WIDTH (DATA_BW)
    ) u_h_lane (
      .clk    (clk),
      .rst    (rst),
      .i_load (accept_c),
      .i_data (i_row_vec[g*DATA_BW +: DATA_BW]),
      .o_data (o_horizontal[g*DATA_BW +: DATA_BW])
    );

    sa_skew_lane #(
      .DEPTH (g + 1),
      .WIDTH (DATA_BW)
    ) u_v_lane (
      .clk    (clk),
      .rst    (rst),
      .i_load (accept_c),
      .i_data (i_col_vec[g*DATA_BW +: DATA_BW]),
      .o_data (o_vertical[g*DATA_BW +: DATA_BW])
    );
  end

endmodule
